// File: rtl/xif_result_buffer_if.sv
// Purpose: bundles the coprocessor result input, commit channel and core result output of the result buffer.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready_o toward the coprocessor, result_ready_i from the core.
interface xif_result_buffer_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [ID_W-1:0]   in_id_i;
    logic [4:0]        in_rd_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_we_i;

    logic              commit_valid_i;
    logic [ID_W-1:0]   commit_id_i;
    logic              commit_kill_i;

    logic              result_valid_o;
    logic              result_ready_i;
    logic [ID_W-1:0]   result_id_o;
    logic [4:0]        result_rd_o;
    logic [DATA_W-1:0] result_data_o;
    logic              result_we_o;

    logic [CNT_W-1:0]  count_o;
    logic              drop_o;

    // Buffer side.
    modport slave (
        input  in_valid_i, in_id_i, in_rd_i, in_data_i, in_we_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  result_ready_i,
        output in_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        output count_o, drop_o
    );

    // Driver side (coprocessor + core).
    modport master (
        output in_valid_i, in_id_i, in_rd_i, in_data_i, in_we_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output result_ready_i,
        input  in_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        input  count_o, drop_o
    );
endinterface

// File: rtl/xif_result_buffer.sv
// Purpose: in-order X-IF result buffer; releases results only once committed, drops killed ones.
// Latency: 1 cycle push-to-result when already committed (0 with XIF_RESULT_BUF_BYPASS_EN on empty FIFO).
// Backpressure: in_ready_o low when full (independent of result_ready_i); head held until result_ready_i.
module xif_result_buffer #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    xif_result_buffer_if.slave xif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NID   = 1 << ID_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic              we;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NID-1:0]     cmt_q, cmt_d;
    logic [NID-1:0]     kill_q, kill_d;

    entry_t             head, in_ent, out_ent;
    logic               empty, in_rdy, head_send, head_drop, byp;
    logic               push, pop, deq, leave;
    logic [ID_W-1:0]    leave_id;

    // Decode head state and handshake events from registered state.
    always_comb begin
        in_ent    = '{id: xif.in_id_i, rd: xif.in_rd_i, data: xif.in_data_i, we: xif.in_we_i};
        head      = mem_q[rd_ptr_q];
        empty     = (count_q == '0);
        in_rdy    = !rst_i && (count_q < CNT_W'(DEPTH));
        head_send = !rst_i && !empty && cmt_q[head.id] && !kill_q[head.id];
        head_drop = !rst_i && !empty && cmt_q[head.id] &&  kill_q[head.id];
`ifdef XIF_RESULT_BUF_BYPASS_EN
        byp       = !rst_i && empty && xif.in_valid_i && cmt_q[xif.in_id_i] && !kill_q[xif.in_id_i];
`else
        byp       = 1'b0;
`endif
        pop       = head_send && xif.result_ready_i;
        deq       = pop || head_drop;
        // A bypassed result taken by the core never enters the FIFO.
        push      = xif.in_valid_i && in_rdy && !(byp && xif.result_ready_i);
        leave     = deq || (byp && xif.result_ready_i);
        leave_id  = empty ? xif.in_id_i : head.id;
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_ent;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Commit table: clear on departure, then set; first commit wins unless the id is leaving now.
    always_comb begin
        cmt_d  = cmt_q;
        kill_d = kill_q;
        if (leave) begin
            cmt_d[leave_id]  = 1'b0;
            kill_d[leave_id] = 1'b0;
        end
        if (xif.commit_valid_i &&
            (!cmt_q[xif.commit_id_i] || (leave && (leave_id == xif.commit_id_i)))) begin
            cmt_d[xif.commit_id_i]  = 1'b1;
            kill_d[xif.commit_id_i] = xif.commit_kill_i;
        end
    end

    // Drive the core-facing result channel and status.
    always_comb begin
        out_ent = '0;
        if (!rst_i) begin
            if (!empty)   out_ent = head;
            else if (byp) out_ent = in_ent;
        end
        xif.in_ready_o     = in_rdy;
        xif.result_valid_o = head_send || byp;
        xif.result_id_o    = out_ent.id;
        xif.result_rd_o    = out_ent.rd;
        xif.result_data_o  = out_ent.data;
        xif.result_we_o    = out_ent.we;
        xif.drop_o         = head_drop;
        xif.count_o        = rst_i ? '0 : count_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmt_q    <= '0;
            kill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmt_q    <= cmt_d;
            kill_q   <= kill_d;
        end
    end
endmodule

// File: tb/tb_xif_result_buffer.sv
// Bench for xif_result_buffer: directed scenarios then random traffic, all checked
// against a queue-based reference model of the commit/release rules.
module tb_xif_result_buffer;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    xif_result_buffer_if #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) xif ();

    xif_result_buffer #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .xif   (xif)
    );

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } ent_t;

    ent_t q[$];
    bit   mcmt [16];
    bit   mkill[16];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [41:0] pk(input ent_t e);
        return {e.id, e.rd, e.data, e.we};
    endfunction

    function automatic bit in_q(input logic [3:0] id);
        foreach (q[i]) if (q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic cycle(input bit rst, input bit vld, input logic [3:0] id, input logic [4:0] rd,
                         input logic [31:0] data, input bit we, input bit cv, input logic [3:0] cid,
                         input bit ck, input bit rr);
        bit          e_valid, e_ready, e_drop, byp, take_head, byp_take, leaving, push, old;
        logic [41:0] e_f;
        logic [3:0]  lid;
        ent_t        ne;
        @(negedge clk_i);
        rst_i              = rst;
        xif.in_valid_i     = vld;
        xif.in_id_i        = id;
        xif.in_rd_i        = rd;
        xif.in_data_i      = data;
        xif.in_we_i        = we;
        xif.commit_valid_i = cv;
        xif.commit_id_i    = cid;
        xif.commit_kill_i  = ck;
        xif.result_ready_i = rr;
        #1;
        ne = '{id: id, rd: rd, data: data, we: we};
        e_ready = !rst && (q.size() < DEPTH);
        e_valid = 0; e_drop = 0; byp = 0; e_f = '0;
        if (!rst) begin
            if (q.size() > 0) begin
                e_f = pk(q[0]);
                if (mcmt[q[0].id]) begin
                    if (mkill[q[0].id]) e_drop = 1;
                    else                e_valid = 1;
                end
            end
`ifdef XIF_RESULT_BUF_BYPASS_EN
            else if (vld && mcmt[id] && !mkill[id]) begin
                byp = 1; e_valid = 1; e_f = pk(ne);
            end
`endif
        end
        check_eq("valid", 64'(xif.result_valid_o), 64'(e_valid));
        check_eq("ready", 64'(xif.in_ready_o), 64'(e_ready));
        check_eq("drop",  64'(xif.drop_o), 64'(e_drop));
        check_eq("count", 64'(xif.count_o), rst ? 64'd0 : 64'(q.size()));
        check_eq("fields", 64'({xif.result_id_o, xif.result_rd_o, xif.result_data_o, xif.result_we_o}), 64'(e_f));
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            foreach (mcmt[i]) begin mcmt[i] = 0; mkill[i] = 0; end
        end else begin
            take_head = (q.size() > 0) && ((e_valid && rr) || e_drop);
            byp_take  = byp && rr;
            lid       = (q.size() > 0) ? q[0].id : id;
            leaving   = take_head || byp_take;
            push      = vld && e_ready && !byp_take;
            old       = mcmt[cid];
            if (take_head) void'(q.pop_front());
            if (push) q.push_back(ne);
            if (leaving) begin mcmt[lid] = 0; mkill[lid] = 0; end
            if (cv && (!old || (leaving && lid == cid))) begin mcmt[cid] = 1; mkill[cid] = ck; end
        end
    endtask

    task automatic idle(input bit rr);
        cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 0, 4'd0, 0, rr);
    endtask

    initial begin
        logic [3:0]  rid, rcid;
        bit          rvld, rcv;
        xif.in_valid_i = 0; xif.in_id_i = '0; xif.in_rd_i = '0; xif.in_data_i = '0; xif.in_we_i = 0;
        xif.commit_valid_i = 0; xif.commit_id_i = '0; xif.commit_kill_i = 0; xif.result_ready_i = 0;

        cycle(1, 0, 4'd0, 5'd0, 32'd0, 0, 0, 4'd0, 0, 0);
        cycle(1, 1, 4'd2, 5'd1, 32'h55, 1, 1, 4'd2, 0, 1);

        // Commit before push, then 1-cycle release.
        cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 1, 4'd3, 0, 0);
        idle(0);
        cycle(0, 1, 4'd3, 5'd5, 32'h7, 1, 0, 4'd0, 0, 0);
        idle(1);
        idle(1);

        // Uncommitted head waits, then commit releases it.
        cycle(0, 1, 4'd2, 5'd9, 32'hdead_beef, 0, 0, 4'd0, 0, 1);
        repeat (4) idle(1);
        cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 1, 4'd2, 0, 1);
        idle(1);
        idle(1);

        // Killed result dropped.
        cycle(0, 1, 4'd1, 5'd3, 32'h1234, 1, 0, 4'd0, 0, 1);
        cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 1, 4'd1, 1, 1);
        repeat (3) idle(1);

        // Fill, stall a fifth push, then drain the head.
        for (int i = 0; i < 4; i++) cycle(0, 1, 4'(i), 5'(i + 1), 32'(i * 3 + 1), 1, 0, 4'd0, 0, 0);
        cycle(0, 1, 4'd4, 5'd4, 32'h44, 1, 1, 4'd0, 0, 1);
        cycle(0, 1, 4'd4, 5'd4, 32'h44, 1, 0, 4'd0, 0, 1);
        cycle(0, 1, 4'd4, 5'd4, 32'h44, 1, 0, 4'd0, 0, 1);
        for (int i = 1; i < 5; i++) cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 1, 4'(i), 0, 1);
        repeat (3) idle(1);

        // Held head with a late kill of the same id.
        cycle(0, 1, 4'd6, 5'd6, 32'hcafe, 1, 1, 4'd6, 0, 0);
        idle(0);
        idle(0);
        cycle(0, 0, 4'd0, 5'd0, 32'd0, 0, 1, 4'd6, 1, 0);
        idle(0);
        idle(0);
        idle(1);
        idle(1);

        // Reset with two entries queued.
        cycle(0, 1, 4'd8, 5'd8, 32'h88, 1, 0, 4'd0, 0, 0);
        cycle(0, 1, 4'd9, 5'd9, 32'h99, 0, 0, 4'd0, 0, 0);
        cycle(1, 0, 4'd0, 5'd0, 32'd0, 0, 0, 4'd0, 0, 0);
        idle(1);
        cycle(0, 1, 4'd0, 5'd2, 32'hab, 1, 1, 4'd0, 0, 1);
        idle(1);
        idle(1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rvld = ($urandom_range(0, 99) < 55);
            rid  = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16 && in_q(rid); k++) rid = rid + 4'd1;
            rcv  = ($urandom_range(0, 99) < 40);
            if (q.size() > 0 && $urandom_range(0, 99) < 75)
                rcid = q[$urandom_range(0, q.size() - 1)].id;
            else
                rcid = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 199) == 0), rvld, rid, 5'($urandom), 32'($urandom), 1'($urandom),
                  rcv, rcid, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
